axi_stream_fifo: RTL and testbench

AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

---
 rtl/common_pkg.sv | 31 +++
 rtl/axi_stream_fifo_if.sv | 35 +++
 rtl/axi_stream_fifo_bram_sdp.sv | 18 +
 rtl/axi_stream_fifo.sv | 111 +++++++++++
 tb/tb_axi_stream_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared stream defaults and word-layout helpers for the stream FIFO slice.
package common_pkg;

    localparam int unsigned MAX_SIM_BYTS = 256;
    localparam int unsigned DEF_DAT_BYTS = 8;
    localparam int unsigned DEF_CTL_BITS = 8;
    localparam int unsigned DEF_DEPTH    = 16;

    function automatic int unsigned mod_bits_for(input int unsigned byts);
        return (byts <= 1) ? 1 : $clog2(byts);
    endfunction

    // Stored word is {err, sop, eop, mod, ctl, dat}
    function automatic int unsigned word_bits(input int unsigned dat_bits,
                                              input int unsigned ctl_bits,
                                              input int unsigned mod_bits);
        return 3 + mod_bits + ctl_bits + dat_bits;
    endfunction

    localparam int unsigned DEF_MOD_BITS = mod_bits_for(DEF_DAT_BYTS);

    typedef struct packed {
        logic                      err;
        logic                      sop;
        logic                      eop;
        logic [DEF_MOD_BITS-1:0]   mod;
        logic [DEF_CTL_BITS-1:0]   ctl;
        logic [DEF_DAT_BYTS*8-1:0] dat;
    } stream_word_t;

endpackage

// File: rtl/axi_stream_fifo_if.sv
// Stream handshake bundle (sink/source views) and the simple dual-port RAM port group.
interface if_axi_stream
    import common_pkg::*;
#(
    parameter int unsigned DAT_BYTS = DEF_DAT_BYTS,
    parameter int unsigned CTL_BITS = DEF_CTL_BITS,
    parameter int unsigned MOD_BITS = mod_bits_for(DAT_BYTS)
) ();
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [MOD_BITS-1:0]   mod;
    logic [CTL_BITS-1:0]   ctl;
    logic [DAT_BYTS*8-1:0] dat;

    modport sink   (input  val, sop, eop, err, mod, ctl, dat, output rdy);
    modport source (output val, sop, eop, err, mod, ctl, dat, input  rdy);
endinterface

interface if_ram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) ();
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport ctrl (output wen, waddr, wdata, ren, raddr, input  rdata);
    modport mem  (input  wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/axi_stream_fifo_bram_sdp.sv
// Simple dual-port RAM with a registered read port; contents are never reset.
module bram_sdp #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned DW    = 8
) (
    input  logic i_clk,
    if_ram.mem   i_ram
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_ram.wen) r_mem[i_ram.waddr] <= i_ram.wdata;
        if (i_ram.ren) r_rdata <= r_mem[i_ram.raddr];
    end

    assign i_ram.rdata = r_rdata;
endmodule

// File: rtl/axi_stream_fifo.sv
// Stream FIFO: DEPTH-1 word RAM whose read register acts as a prefetch stage,
// followed by the o_axi output register; o_count covers every held word.
module axi_stream_fifo
    import common_pkg::*;
#(
    parameter int unsigned DAT_BYTS = DEF_DAT_BYTS,
    parameter int unsigned DAT_BITS = DAT_BYTS * 8,
    parameter int unsigned CTL_BITS = DEF_CTL_BITS,
    parameter int unsigned MOD_BITS = mod_bits_for(DAT_BYTS),
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    if_axi_stream.sink             i_axi,
    if_axi_stream.source           o_axi,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int unsigned RAM_DEPTH = DEPTH - 1;
    localparam int unsigned PTR_W     = $clog2(RAM_DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned WORD_W    = word_bits(DAT_BITS, CTL_BITS, MOD_BITS);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_ram_cnt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_pf_val;
    logic              r_out_val;
    logic              r_in_rdy;
    logic              r_full;
    logic              r_empty;
    logic [WORD_W-1:0] r_out_word;
    logic [WORD_W-1:0] w_in_word;
    logic              w_push;
    logic              w_pop;
    logic              w_out_take;
    logic              w_ren;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    if_ram #(.AW(PTR_W), .DW(WORD_W)) u_ram_if ();

    bram_sdp #(.DEPTH(RAM_DEPTH), .DW(WORD_W)) u_ram (
        .i_clk (i_clk),
        .i_ram (u_ram_if)
    );

    assign w_in_word      = {i_axi.err, i_axi.sop, i_axi.eop, i_axi.mod, i_axi.ctl, i_axi.dat};
    assign u_ram_if.wen   = w_push;
    assign u_ram_if.waddr = r_wr_ptr;
    assign u_ram_if.wdata = w_in_word;
    assign u_ram_if.ren   = w_ren;
    assign u_ram_if.raddr = r_rd_ptr;

    // Prefetch refills in the same cycle the output register takes its word
    always_comb begin
        w_push      = i_axi.val && r_in_rdy;
        w_pop       = r_out_val && o_axi.rdy;
        w_out_take  = r_pf_val && (!r_out_val || o_axi.rdy);
        w_ren       = (r_ram_cnt != '0) && (!r_pf_val || w_out_take);
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
        else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_count    <= '0;
            r_pf_val   <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_word <= '0;
            r_in_rdy   <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_ren)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_ram_cnt <= r_ram_cnt + CNT_W'(w_push) - CNT_W'(w_ren);

            if (w_ren)           r_pf_val <= 1'b1;
            else if (w_out_take) r_pf_val <= 1'b0;

            if (w_out_take) begin
                r_out_val  <= 1'b1;
                r_out_word <= u_ram_if.rdata;
            end else if (w_pop) begin
                r_out_val  <= 1'b0;
            end

            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty  <= (w_count_nxt == '0);
            r_in_rdy <= (w_count_nxt != CNT_W'(DEPTH));
        end
    end

    assign i_axi.rdy = r_in_rdy;
    assign o_axi.val = r_out_val;
    assign {o_axi.err, o_axi.sop, o_axi.eop, o_axi.mod, o_axi.ctl, o_axi.dat} = r_out_word;
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
endmodule

// File: tb/tb_axi_stream_fifo.sv
// Randomised bench for axi_stream_fifo against a queue-based reference model.
module tb_axi_stream_fifo;
    import common_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DB    = 8;
    localparam int unsigned CB    = 8;
    localparam int unsigned MB    = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB), .MOD_BITS(MB)) in_if ();
    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB), .MOD_BITS(MB)) out_if ();

    axi_stream_fifo #(.DAT_BYTS(DB), .CTL_BITS(CB), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_axi   (in_if),
        .o_axi   (out_if),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    always #5 clk = ~clk;

    stream_word_t tx_q[$];
    stream_word_t mq[$];
    stream_word_t rx_q[$];
    int unsigned  mt[$];
    byte unsigned exp_flat[$];
    byte unsigned pk_bytes[$];
    int unsigned  lens[$];
    int unsigned  pk_beats;
    int unsigned  cyc, n_vec, n_err;
    int unsigned  bp, gap;
    int           first_push, first_val;
    bit           rdy_ok;

    task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic stream_word_t out_word();
        stream_word_t w;
        w.err = out_if.err; w.sop = out_if.sop; w.eop = out_if.eop;
        w.mod = out_if.mod; w.ctl = out_if.ctl; w.dat = out_if.dat;
        return w;
    endfunction

    function automatic stream_word_t in_word();
        stream_word_t w;
        w.err = in_if.err; w.sop = in_if.sop; w.eop = in_if.eop;
        w.mod = in_if.mod; w.ctl = in_if.ctl; w.dat = in_if.dat;
        return w;
    endfunction

    // Head word is due at the output two edges after it was accepted
    function automatic bit val_due();
        return (mq.size() != 0) && (cyc - mt[0] >= 2);
    endfunction

    task automatic set_in_head();
        in_if.val = 1'b1;
        in_if.err = tx_q[0].err; in_if.sop = tx_q[0].sop; in_if.eop = tx_q[0].eop;
        in_if.mod = tx_q[0].mod; in_if.ctl = tx_q[0].ctl; in_if.dat = tx_q[0].dat;
    endtask

    task automatic drive();
        if (tx_q.size() != 0 && $urandom_range(99) >= gap) begin
            set_in_head();
        end else begin
            in_if.val = 1'b0;
            in_if.err = 1'($urandom); in_if.sop = 1'($urandom); in_if.eop = 1'($urandom);
            in_if.mod = 3'($urandom); in_if.ctl = 8'($urandom);
            in_if.dat = {$urandom(), $urandom()};
        end
        out_if.rdy = ($urandom_range(99) >= bp);
    endtask

    task automatic check_state();
        bit ev;
        chk_eq("count", count, mq.size());
        chk_eq("in_rdy", in_if.rdy, mq.size() != DEPTH);
        chk_eq("full", full, mq.size() == DEPTH);
        chk_eq("empty", empty, mq.size() == 0);
        ev = val_due();
        chk_eq("out_val", out_if.val, ev);
        if (ev) chk_eq("out_word", out_word(), mq[0]);
        if (out_if.val && first_val < 0) first_val = int'(cyc);
    endtask

    task automatic tick();
        bit push, pop;
        push = in_if.val && rdy_ok && (mq.size() != DEPTH);
        pop  = val_due() && out_if.rdy;
        if (pop) begin
            rx_q.push_back(out_word());
            void'(mq.pop_front());
            void'(mt.pop_front());
        end
        if (push) begin
            mq.push_back(in_word());
            mt.push_back(cyc + 1);
            void'(tx_q.pop_front());
            if (first_push < 0) first_push = int'(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        rdy_ok = 1'b1;
        check_state();
    endtask

    task automatic run_drain(input int unsigned budget);
        int unsigned k = 0;
        while ((tx_q.size() != 0 || mq.size() != 0) && k < budget) begin
            drive();
            tick();
            k++;
        end
        chk_eq("drain_left", tx_q.size() + mq.size(), 0);
        in_if.val  = 1'b0;
        out_if.rdy = 1'b0;
    endtask

    task automatic clear_model();
        mq.delete(); mt.delete(); tx_q.delete(); rx_q.delete(); exp_flat.delete();
        rdy_ok = 1'b0;
    endtask

    task automatic put_stream(input int unsigned len, input logic [7:0] ctl, input bit err);
        stream_word_t w;
        int unsigned  nb;
        byte unsigned b;
        nb = (len + 7) / 8;
        for (int unsigned k = 0; k < nb; k++) begin
            w = '0;
            for (int unsigned i = 0; i < 8; i++) begin
                if (k * 8 + i < len) begin
                    b = 8'($urandom);
                    w.dat[i*8 +: 8] = b;
                    exp_flat.push_back(b);
                end
            end
            w.sop = (k == 0);
            w.eop = (k == nb - 1);
            w.mod = w.eop ? 3'(len % 8) : 3'd0;
            w.ctl = ctl;
            w.err = err && w.eop;
            tx_q.push_back(w);
        end
    endtask

    task automatic put_words(input int unsigned n);
        stream_word_t w;
        for (int unsigned i = 0; i < n; i++) begin
            w = '0;
            w.dat = {32'hC0DE_0000, i};
            w.ctl = 8'(i);
            w.sop = (i == 0);
            w.eop = (i == n - 1);
            tx_q.push_back(w);
        end
    endtask

    task automatic get_stream();
        stream_word_t w;
        int unsigned  nb;
        pk_bytes.delete();
        pk_beats = 0;
        while (rx_q.size() != 0) begin
            w = rx_q.pop_front();
            pk_beats++;
            nb = (w.eop && w.mod != 0) ? 32'(w.mod) : 8;
            for (int unsigned i = 0; i < nb; i++) pk_bytes.push_back(w.dat[i*8 +: 8]);
            if (w.eop) break;
        end
    endtask

    task automatic cmp_stream(input string tag, input int unsigned len);
        int unsigned  bad = 0;
        byte unsigned e;
        get_stream();
        chk_eq({tag, "_len"}, pk_bytes.size(), len);
        for (int unsigned i = 0; i < len; i++) begin
            e = exp_flat.pop_front();
            if (i >= pk_bytes.size() || pk_bytes[i] != e) bad++;
        end
        chk_eq({tag, "_bytes"}, bad, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned k;
        n_vec = 0; n_err = 0; cyc = 0; bp = 0; gap = 0;
        first_push = -1; first_val = -1;
        rst_n = 1'b0;
        in_if.val = 1'b0; in_if.err = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
        in_if.mod = '0; in_if.ctl = '0; in_if.dat = '0;
        out_if.rdy = 1'b0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_val", out_if.val, 0);
        chk_eq("rst_dat", out_word(), 0);
        chk_eq("rst_count", count, 0);
        chk_eq("rst_empty", empty, 1);
        chk_eq("rst_full", full, 0);
        chk_eq("rst_rdy", in_if.rdy, 0);
        rst_n = 1'b1;

        // 64-byte packet, no backpressure
        put_stream(64, 8'h11, 1'b0);
        run_drain(100);
        chk_eq("t1_latency", first_val - first_push, 2);
        chk_eq("t1_beats", rx_q.size(), 8);
        if (rx_q.size() == 8) begin
            chk_eq("t1_sop0", rx_q[0].sop, 1);
            chk_eq("t1_eop7", rx_q[7].eop, 1);
            chk_eq("t1_mod7", rx_q[7].mod, 0);
            chk_eq("t1_eop0", rx_q[0].eop, 0);
        end
        cmp_stream("t1", 64);

        // Sink stalled while 20 beats are offered
        bp = 100; gap = 0;
        put_words(20);
        repeat (25) begin drive(); tick(); end
        chk_eq("t2_count", count, 16);
        chk_eq("t2_full", full, 1);
        chk_eq("t2_rdy", in_if.rdy, 0);
        bp = 0;
        run_drain(100);
        chk_eq("t2_beats", rx_q.size(), 20);
        for (int unsigned i = 0; i < 20; i++) begin
            if (i < rx_q.size()) chk_eq("t2_order", rx_q[i].dat, {32'hC0DE_0000, i});
        end
        rx_q.delete();

        // 13-byte packet with sideband control
        bp = 0;
        put_stream(13, 8'hA5, 1'b0);
        run_drain(100);
        chk_eq("t3_beats", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk_eq("t3_eop0", rx_q[0].eop, 0);
            chk_eq("t3_eop1", rx_q[1].eop, 1);
            chk_eq("t3_mod1", rx_q[1].mod, 5);
            chk_eq("t3_ctl0", rx_q[0].ctl, 8'hA5);
            chk_eq("t3_ctl1", rx_q[1].ctl, 8'hA5);
        end
        cmp_stream("t3", 13);

        // Full with a simultaneous pop and write
        bp = 100; gap = 0;
        put_words(17);
        k = 0;
        while (mq.size() != DEPTH && k < 40) begin drive(); tick(); k++; end
        chk_eq("t4_full", count, 16);
        set_in_head(); out_if.rdy = 1'b1;
        tick();
        chk_eq("t4_cnt_pop", count, 15);
        set_in_head(); out_if.rdy = 1'b0;
        tick();
        chk_eq("t4_cnt_wr", count, 16);
        bp = 0;
        run_drain(100);
        chk_eq("t4_beats", rx_q.size(), 17);
        rx_q.delete();

        // Asynchronous reset with 7 words held
        bp = 100; gap = 0;
        put_words(10);
        k = 0;
        while (mq.size() != 7 && k < 40) begin drive(); tick(); k++; end
        in_if.val = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_eq("t5_val", out_if.val, 0);
        chk_eq("t5_count", count, 0);
        chk_eq("t5_empty", empty, 1);
        chk_eq("t5_rdy", in_if.rdy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        out_if.rdy = 1'b0;
        tick();
        chk_eq("t5_rdy_up", in_if.rdy, 1);
        bp = 30;
        put_stream(40, 8'h3C, 1'b0);
        run_drain(200);
        cmp_stream("t5", 40);

        // 1000 random packets under 50% backpressure
        bp = 50; gap = 20;
        rx_q.delete(); exp_flat.delete(); lens.delete();
        for (int p = 0; p < 1000; p++) begin
            k = $urandom_range(200, 1);
            lens.push_back(k);
            put_stream(k, 8'($urandom), ($urandom_range(9) == 0));
        end
        run_drain(80000);
        for (int p = 0; p < 1000; p++) cmp_stream("t6", lens[p]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
